// File: rtl/packet_transmitter_pkg.sv
// Shared definitions for the key-exchange link: transmitter states, framing
// bytes and message codes also used by the key-exchange FSM and receiver.
package packet_transmitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PAYLOAD,
    ST_CHECK,
    ST_GAP
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE      = 8'hD5;
  localparam logic [7:0] NO_ACK_MESSAGE = 8'h55;
  localparam logic [7:0] ACK_MESSAGE    = 8'hAA;

  localparam int DEFAULT_PACKET_LEN = 33;

endpackage

// File: rtl/packet_transmitter_buffer.sv
// Packet RAM: one write port, one synchronous read port with read-before-write
// behaviour on address collisions.
module packet_buffer
  import packet_transmitter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LOGSIZE = 6
) (
  input  logic               clock_i,
  input  logic               wr_en_i,
  input  logic [LOGSIZE-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  input  logic               rd_en_i,
  input  logic [LOGSIZE-1:0] rd_addr_i,
  output logic [WIDTH-1:0]   rd_data_o
);

  logic [WIDTH-1:0] mem_q [2**LOGSIZE];
  logic [WIDTH-1:0] rd_data_q;

  // The read register only moves when enabled so a stalled byte stays put.
  always_ff @(posedge clock_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/packet_transmitter.sv
// Frames the key-exchange packet RAM as SYNC, payload, checksum on a
// valid/ready byte link and repeats the frame after a gap while sending.
module packet_transmitter #(
  parameter int               WIDTH      = 8,
  parameter int               LOGSIZE    = 6,
  parameter int               PACKET_LEN = packet_transmitter_pkg::DEFAULT_PACKET_LEN,
  parameter int               RESEND_GAP = 16,
  parameter logic [WIDTH-1:0] SYNC_BYTE  = WIDTH'(packet_transmitter_pkg::SYNC_BYTE)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LOGSIZE-1:0] write_index,
  input  logic [WIDTH-1:0]   write_data,
  input  logic               write_enable,
  input  logic               sending,
  output logic [WIDTH-1:0]   tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_sop,
  output logic               tx_eop,
  output logic               busy,
  output logic [15:0]        frames_sent
);

  import packet_transmitter_pkg::*;

  localparam logic [LOGSIZE-1:0] LAST_IDX = LOGSIZE'(PACKET_LEN - 1);
  localparam logic [15:0]        GAP_LAST = 16'(RESEND_GAP - 1);

  tx_state_e          state_q;
  logic [LOGSIZE-1:0] idx_q;
  logic [15:0]        gap_q;
  logic [WIDTH-1:0]   checksum_q;
  logic [WIDTH-1:0]   data_q;
  logic               from_ram_q;
  logic               valid_q;
  logic               sop_q;
  logic               eop_q;
  logic [15:0]        frames_q;

  logic               xfer;
  logic               rd_en;
  logic [LOGSIZE-1:0] rd_addr;
  logic [WIDTH-1:0]   ram_rdata;
  logic [WIDTH-1:0]   sum_d;

  assign xfer    = valid_q && tx_ready;
  assign sum_d   = checksum_q + tx_data;
  assign rd_en   = xfer && ((state_q == ST_SYNC) ||
                            ((state_q == ST_PAYLOAD) && (idx_q != LAST_IDX)));
  assign rd_addr = (state_q == ST_SYNC) ? '0 : idx_q + 1'b1;

  packet_buffer #(
    .WIDTH   (WIDTH),
    .LOGSIZE (LOGSIZE)
  ) u_buffer (
    .clock_i   (clock),
    .wr_en_i   (write_enable),
    .wr_addr_i (write_index),
    .wr_data_i (write_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (ram_rdata)
  );

  // Payload bytes come straight from the RAM read register; SYNC and the
  // checksum come from data_q, so every link output is a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      checksum_q <= '0;
      data_q     <= '0;
      from_ram_q <= 1'b0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      frames_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sending) begin
            state_q <= ST_SYNC;
            valid_q <= 1'b1;
            sop_q   <= 1'b1;
            data_q  <= SYNC_BYTE;
          end
        end
        ST_SYNC: begin
          if (xfer) begin
            state_q    <= ST_PAYLOAD;
            idx_q      <= '0;
            sop_q      <= 1'b0;
            from_ram_q <= 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (xfer) begin
            checksum_q <= sum_d;
            if (idx_q == LAST_IDX) begin
              state_q    <= ST_CHECK;
              from_ram_q <= 1'b0;
              data_q     <= sum_d;
              eop_q      <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (xfer) begin
            frames_q   <= frames_q + 16'd1;
            checksum_q <= '0;
            eop_q      <= 1'b0;
            gap_q      <= '0;
            // A zero gap chains straight into the next SYNC.
            if ((RESEND_GAP == 0) && sending) begin
              state_q <= ST_SYNC;
              sop_q   <= 1'b1;
              data_q  <= SYNC_BYTE;
            end else begin
              valid_q <= 1'b0;
              state_q <= (RESEND_GAP == 0) ? ST_IDLE : ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (sending) begin
              state_q <= ST_SYNC;
              valid_q <= 1'b1;
              sop_q   <= 1'b1;
              data_q  <= SYNC_BYTE;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_data     = from_ram_q ? ram_rdata : data_q;
  assign tx_valid    = valid_q;
  assign tx_sop      = sop_q;
  assign tx_eop      = eop_q;
  assign busy        = (state_q != ST_IDLE);
  assign frames_sent = frames_q;

endmodule

// File: doc/packet_transmitter.md
# packet_transmitter

Frames and serialises the outgoing packet buffer written by the key-exchange FSM onto the byte-wide link toward the peer. Holds a `2^LOGSIZE` x `WIDTH` packet RAM with a single write port. While `sending` is high, it transmits the packet as a framed byte stream with valid/ready handshake. It retransmits the frame after a fixed idle gap until `sending` drops, because the protocol relies on repeated sends until the peer acknowledges.

## Interface
- `WIDTH`, 8: byte width of RAM entries and link data.
- `LOGSIZE`, 6: RAM address width.
- `PACKET_LEN`, 33: payload bytes per frame (header at index 0, key bytes at 1..32); legal range 1..`2^LOGSIZE`.
- `RESEND_GAP`, 16: idle cycles between frames; 0 legal.
- `SYNC_BYTE`, 8'hD5: start-of-frame byte.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `write_index`  in  `LOGSIZE`  RAM write address.
- `write_data`  in  `WIDTH`  RAM write data.
- `write_enable`  in  1  write strobe, honoured every cycle in every state.
- `sending`  in  1  level request to transmit or retransmit.
- `tx_data`  out  `WIDTH`  link byte (registered).
- `tx_valid`  out  1  byte valid.
- `tx_ready`  in  1  sink accepts; a transfer occurs when `tx_valid && tx_ready` at a rising edge.
- `tx_sop`  out  1  high with the SYNC byte.
- `tx_eop`  out  1  high with the checksum byte.
- `busy`  out  1  state is not IDLE.
- `frames_sent`  out  16  completed frames, wraps at 2^16.

## Operation
- Frame format: `SYNC_BYTE`, RAM[0..PACKET_LEN-1], then checksum.
- Checksum: the sum of the transmitted payload bytes mod 2^`WIDTH`.
- States and transitions:
  - IDLE: on `sending`, go to SYNC.
  - SYNC: present `SYNC_BYTE` with `tx_sop`; on transfer, go to PAYLOAD with index 0.
  - PAYLOAD: present RAM[index]; on transfer, add the byte to the checksum and increment index. After index `PACKET_LEN-1` transfers, go to CHECK.
  - CHECK: present the checksum with `tx_eop`. On transfer, increment `frames_sent`, clear the checksum, and go to GAP.
  - GAP: count `RESEND_GAP` cycles. At the end, go to SYNC if `sending`, otherwise IDLE.
- Frames are atomic. If `sending` drops mid-frame, the frame completes and the block then goes to GAP, then IDLE.
- Writes are never blocked. A payload byte's transmitted value is the RAM content read at the edge that loads it into `tx_data`. A same-cycle write to the same address gives the old value (read-before-write).
- RAM contents are not reset.

## Timing
- Reset (async) forces the following immediately: state IDLE, `tx_valid`=0, `tx_sop`=0, `tx_eop`=0, `tx_data`=0, `busy`=0, `frames_sent`=0, checksum=0. Reset mid-frame abandons the frame without emitting an EOP.
- `sending` sampled high in IDLE at edge N: `tx_valid`=1 with SYNC from N+1.
- While `tx_valid && !tx_ready`, `tx_data`, `tx_sop` and `tx_eop` are held stable.
- With `tx_ready` held at 1, one byte transfers per cycle; a frame takes `PACKET_LEN`+2 cycles.
- GAP: `tx_valid` is low for exactly `RESEND_GAP` cycles after the EOP transfer.
  - With `RESEND_GAP`=0, SYNC is valid in the cycle right after the EOP transfer if `sending` is high; otherwise the block goes to IDLE.
- `busy` is high from the cycle SYNC is presented until the cycle after GAP ends.

## Structure
- Shared package holds:
  - the state enum;
  - `SYNC_BYTE`;
  - `NO_ACK_MESSAGE` 8'h55 and `ACK_MESSAGE` 8'hAA, shared with the key-exchange FSM and the future receiver;
  - the default `PACKET_LEN`.
- One sub-module: `packet_buffer`, a simple dual-port RAM (1 write, 1 synchronous read, read-before-write).

## Test plan
- Basic frame: write 0x55 at index 0 and bytes 1..32 at indices 1..32, raise `sending`, hold `tx_ready`=1.
  - Expected stream: D5(sop), 55, 01..20, 65(eop); `frames_sent`=1.
- Backpressure: same frame with `tx_ready` pseudo-random at 50%.
  - Same byte sequence; outputs stable during every stall.
- Resend: keep `sending` high, `RESEND_GAP`=16.
  - The second SYNC appears exactly 16 idle cycles after the first EOP; `frames_sent`=2.
- Update during gap: rewrite index 0 to 0xAA during GAP.
  - Next frame header is AA and its checksum is BA.
- `sending` dropped mid-payload: the frame completes through EOP, then GAP, IDLE, `busy`=0, and no further SYNC.
- Reset at payload byte 10: outputs zero in the same cycle, `frames_sent`=0.
  - After release with `sending` high, a full frame restarts at SYNC.
